// File: rtl/vin_delta_pkg.sv
// rtl/vin_delta_pkg.sv - shared IEEE-754 double constants and field layout
// Purpose: constants and the unpacked view of an IEEE double used by the
//          vin/delta splitter and the other normalisers in the datapath.
package vin_delta_pkg;

  localparam logic [10:0] DBL_BIAS_M1 = 11'd1022;
  localparam int          DBL_W       = 64;
  localparam int          MANT_W      = 52;

  typedef struct packed {
    logic              s;
    logic [10:0]       e;
    logic [MANT_W-1:0] m;
  } dbl_t;

endpackage

// File: rtl/lzc64.sv
// rtl/lzc64.sv - 64-bit leading-zero counter
// Purpose: combinational priority count of leading zeros in six halving levels.
// Ports:
//   i_data  in  64  value to scan
//   o_lz    out 6   leading-zero count (63 when i_data is zero)
//   o_zero  out 1   i_data == 0
module lzc64 (
  input  logic [63:0] i_data,
  output logic [5:0]  o_lz,
  output logic        o_zero
);

  logic [31:0] w_v32;
  logic [15:0] w_v16;
  logic [7:0]  w_v8;
  logic [3:0]  w_v4;
  logic [1:0]  w_v2;

  // Each level asks whether the upper half is empty; if so the count gains
  // that half's width and the search continues in the lower half.
  assign o_lz[5] = (i_data[63:32] == '0);
  assign w_v32   = o_lz[5] ? i_data[31:0] : i_data[63:32];
  assign o_lz[4] = (w_v32[31:16] == '0);
  assign w_v16   = o_lz[4] ? w_v32[15:0] : w_v32[31:16];
  assign o_lz[3] = (w_v16[15:8] == '0);
  assign w_v8    = o_lz[3] ? w_v16[7:0] : w_v16[15:8];
  assign o_lz[2] = (w_v8[7:4] == '0);
  assign w_v4    = o_lz[2] ? w_v8[3:0] : w_v8[7:4];
  assign o_lz[1] = (w_v4[3:2] == '0);
  assign w_v2    = o_lz[1] ? w_v4[1:0] : w_v4[3:2];
  assign o_lz[0] = ~w_v2[1];

  // The final pair is all-zero only if every half chosen on the way was empty.
  assign o_zero  = (w_v2 == 2'b00);

endmodule

// File: rtl/vin_delta_pipe.sv
// rtl/vin_delta_pipe.sv - 3-stage split of a double in [0,1) into table index and residual
// Purpose: vin = floor(x*2^VIN_W), delta = frac(x*2^VIN_W) re-packed as a double
//          (truncated), with push/stop flow control and 3-cycle latency.
// Ports:
//   clk      in  1      clock, rising edge
//   rst      in  1      asynchronous active-high reset
//   pushin   in  1      rand_in valid
//   rand_in  in  64     IEEE double x
//   stopout  out 1      stage 1 cannot accept; upstream holds
//   pushout  out 1      vin/delta/oor valid
//   stopin   in  1      downstream stall
//   vin      out VIN_W  bin index
//   delta    out 64     residual as IEEE double
//   oor      out 1      input out of range
module vin_delta_pipe
  import vin_delta_pkg::*;
#(
  parameter int VIN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushin,
  input  logic [63:0]      rand_in,
  output logic             stopout,
  output logic             pushout,
  input  logic             stopin,
  output logic [VIN_W-1:0] vin,
  output logic [63:0]      delta,
  output logic             oor
);

  // Flow control: a stage advances when it is empty or its successor advances.
  logic r_v1, r_v2, r_v3;
  logic w_adv1, w_adv2, w_adv3;

  assign w_adv3  = ~r_v3 | ~stopin;
  assign w_adv2  = ~r_v2 | w_adv3;
  assign w_adv1  = ~r_v1 | w_adv2;
  assign stopout = r_v1 & ~w_adv2;

  // Stage 1: denormalise into a 64-bit fixed-point fraction.
  dbl_t        w_in;
  logic        w_oor1;
  logic [10:0] w_shamt;
  logic [63:0] w_x1;

  assign w_in    = rand_in;
  assign w_oor1  = (w_in.e > DBL_BIAS_M1) || (w_in.s && ({w_in.e, w_in.m} != '0));
  assign w_shamt = DBL_BIAS_M1 - w_in.e;

  always_comb begin
    w_x1 = '0;
    if (w_in.e > DBL_BIAS_M1)
      w_x1 = '1;
    else if ((w_in.e != 11'd0) && (w_shamt < 11'd64))
      w_x1 = {1'b1, w_in.m, 11'b0} >> w_shamt[5:0];
  end

  logic [63:0] r_x1;
  logic        r_s1, r_oor1;

  // Stage 2: split index from fraction and count the fraction's leading zeros.
  logic [VIN_W-1:0] w_vin2;
  logic [63:0]      w_r2;
  logic [5:0]       w_lz2;
  logic             w_z2;

  assign w_vin2 = r_x1[63 -: VIN_W];
  assign w_r2   = r_x1 << VIN_W;

  lzc64 u_lzc (
    .i_data (w_r2),
    .o_lz   (w_lz2),
    .o_zero (w_z2)
  );

  logic [VIN_W-1:0] r_vin2;
  logic [63:0]      r_r2;
  logic [5:0]       r_lz2;
  logic             r_z2, r_s2, r_oor2;

  // Stage 3: normalise and pack. The hidden one lands in bit 63 and is dropped.
  logic [51:0]      w_mant3;
  logic [10:0]      w_exp3;
  logic [63:0]      w_delta3;
  logic [VIN_W-1:0] w_vin3;

  assign w_mant3  = 52'((r_r2 << r_lz2) >> 11);
  assign w_exp3   = DBL_BIAS_M1 - {5'b0, r_lz2};
  assign w_delta3 = (r_z2 | r_oor2) ? 64'h0 : {r_s2, w_exp3, w_mant3};
  assign w_vin3   = r_oor2 ? {VIN_W{1'b1}} : r_vin2;

  logic [VIN_W-1:0] r_vin;
  logic [63:0]      r_delta;
  logic             r_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_x1    <= '0;
      r_s1    <= 1'b0;
      r_oor1  <= 1'b0;
      r_vin2  <= '0;
      r_r2    <= '0;
      r_lz2   <= '0;
      r_z2    <= 1'b0;
      r_s2    <= 1'b0;
      r_oor2  <= 1'b0;
      r_vin   <= '0;
      r_delta <= '0;
      r_oor   <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= pushin;
        if (pushin) begin
          r_x1   <= w_x1;
          r_s1   <= w_in.s;
          r_oor1 <= w_oor1;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_vin2 <= w_vin2;
          r_r2   <= w_r2;
          r_lz2  <= w_lz2;
          r_z2   <= w_z2;
          r_s2   <= r_s1;
          r_oor2 <= r_oor1;
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_vin   <= w_vin3;
          r_delta <= w_delta3;
          r_oor   <= r_oor2;
        end
      end
    end
  end

  assign pushout = r_v3;
  assign vin     = r_vin;
  assign delta   = r_delta;
  assign oor     = r_oor;

endmodule

// File: tb/tb_vin_delta_pipe.sv
// tb/tb_vin_delta_pipe.sv - scoreboard bench for vin_delta_pipe
module tb_vin_delta_pipe;

  localparam int W = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pushin = 1'b0;
  logic          stopin = 1'b0;
  logic [63:0]   rand_in = '0;
  logic          stopout, pushout, oor;
  logic [W-1:0]  vin;
  logic [63:0]   delta;

  logic          p9 = 1'b0;
  logic [63:0]   x9 = '0;
  logic          so9, po9, o9;
  logic [8:0]    v9;
  logic [63:0]   d9;

  always #5 clk = ~clk;

  vin_delta_pipe #(.VIN_W(W)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .rand_in(rand_in), .stopout(stopout),
    .pushout(pushout), .stopin(stopin), .vin(vin), .delta(delta), .oor(oor)
  );

  vin_delta_pipe #(.VIN_W(9)) dut9 (
    .clk(clk), .rst(rst), .pushin(p9), .rand_in(x9), .stopout(so9),
    .pushout(po9), .stopin(1'b0), .vin(v9), .delta(d9), .oor(o9)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] v;
    logic [63:0]  d;
    logic         o;
  } exp_t;

  exp_t q[$];
  exp_t e_new, e_got;

  // Reference: x*2^64 as an exact 128-bit integer, then truncate to 64 bits.
  function automatic exp_t model(input logic [63:0] x);
    exp_t         r;
    logic [10:0]  e;
    logic [127:0] val;
    logic [63:0]  fr, sh;
    int           p;
    e = x[62:52];
    r.o = (e >= 11'd1023) || (x[63] && (x[62:0] != '0));
    if (r.o) begin
      r.v = '1;
      r.d = '0;
      return r;
    end
    if (e == 11'd0) val = '0;
    else begin
      val = {75'b0, 1'b1, x[51:0]};
      if (e >= 11'd1011) val = val << (e - 11'd1011);
      else               val = val >> (11'd1011 - e);
    end
    r.v = val[63:64-W];
    fr  = val[63:0] << W;
    p = -1;
    for (int i = 0; i < 64; i++) if (fr[i]) p = i;
    if (p < 0) r.d = '0;
    else begin
      sh  = fr << (63 - p);
      r.d = {x[63], 11'(959 + p), sh[62:11]};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (pushout && !stopin) begin
        if (q.size() == 0) chk("sb_unexpected_output", 64'd1, 64'd0);
        else begin
          e_got = q.pop_front();
          chk("sb_vin",   64'(vin),   64'(e_got.v));
          chk("sb_delta", delta,      e_got.d);
          chk("sb_oor",   64'(oor),   64'(e_got.o));
        end
      end
      if (pushin && !stopout) begin
        e_new = model(rand_in);
        q.push_back(e_new);
      end
    end
  end

  bit rnd_mode = 1'b0;

  task automatic send(input logic [63:0] x);
    bit acc;
    int budget;
    pushin  = 1'b1;
    rand_in = x;
    acc     = 1'b0;
    budget  = 0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = !stopout;
      @(posedge clk);
      #1;
      budget++;
      if (rnd_mode) stopin = ($urandom_range(0, 3) == 0);
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    pushin = 1'b0;
  endtask

  task automatic one_shot(input logic [63:0] x, input logic [W-1:0] ev,
                          input logic [63:0] ed, input logic eo);
    int n;
    send(x);
    n = 1;
    while (!pushout && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'd3);
    chk("dir_vin", 64'(vin), 64'(ev));
    chk("dir_delta", delta, ed);
    chk("dir_oor", 64'(oor), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  logic [63:0] x_r;
  int          n9;

  initial begin
    #2 rst = 1'b1;
    #2;
    chk("rst_pushout", 64'(pushout), 64'd0);
    chk("rst_vin",     64'(vin),     64'd0);
    chk("rst_delta",   delta,        64'd0);
    chk("rst_oor",     64'(oor),     64'd0);
    chk("rst_stopout", 64'(stopout), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    one_shot(64'h3FE8000000000000, 10'd768,  64'h0,                0);
    one_shot(64'h3FE0040000000000, 10'd512,  64'h3FE0000000000000, 0);
    one_shot(64'h3FF0000000000000, 10'd1023, 64'h0,                1);
    one_shot(64'h0000000000000000, 10'd0,    64'h0,                0);
    one_shot(64'hBFE0000000000000, 10'd1023, 64'h0,                1);
    one_shot(64'h8000000000000000, 10'd0,    64'h0,                0);
    one_shot(64'h7FF8000000000000, 10'd1023, 64'h0,                1);
    one_shot(64'h3CB0000000000000, 10'd0,    64'h3D50000000000000, 0);

    p9 = 1'b1;
    x9 = 64'h3FD0000000000000;
    @(posedge clk);
    #1 p9 = 1'b0;
    n9 = 1;
    while (!po9 && n9 < 10) begin
      @(posedge clk);
      #1;
      n9++;
    end
    chk("w9_latency", 64'(n9), 64'd3);
    chk("w9_vin",   64'(v9), 64'd128);
    chk("w9_delta", d9,      64'h0);
    chk("w9_oor",   64'(o9), 64'd0);

    stopin = 1'b1;
    fork
      begin
        send(64'h3FE8000000000000);
        send(64'h3FE0040000000000);
        send(64'h3FC3456789ABCDEF);
        send(64'h3FEFFFFFFFFFFFFF);
        send(64'h3F50000000000001);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("stall_stopout", 64'(stopout), 64'd1);
        chk("stall_pushout", 64'(pushout), 64'd1);
        @(posedge clk);
        #2 stopin = 1'b0;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stall_drain", 64'(q.size()), 64'd0);

    send(64'h3FE1111111111111);
    send(64'h3FE2222222222222);
    send(64'h3FE3333333333333);
    rst = 1'b1;
    #1;
    chk("midrst_pushout", 64'(pushout), 64'd0);
    chk("midrst_stopout", 64'(stopout), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    one_shot(64'h3FE0040000000000, 10'd512, 64'h3FE0000000000000, 0);

    rnd_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      stopin = ($urandom_range(0, 3) == 0);
      x_r = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0)
        x_r = {1'b0, 11'(1022 - $urandom_range(0, 70)), x_r[51:0]};
      if ($urandom_range(0, 4) != 0) send(x_r);
      else begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    stopin   = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
